// File: rtl/operand_fetch_unit.sv
// Operand fetch sequencer in front of the single-port register file.
// Owns all register-file strobes: reads, writeback and stack pulses.
module operand_fetch_unit #(
   parameter int DATA_W = 16,
   parameter int ID_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dec_valid,
   output logic              dec_ready,
   input  logic [ID_W-1:0]   dec_src_a,
   input  logic [ID_W-1:0]   dec_src_b,
   input  logic              dec_uses_b,
   input  logic [ID_W-1:0]   dec_dst,
   input  logic [1:0]        dec_stack_op,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic [ID_W-1:0]   op_dst,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [ID_W-1:0]   wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   output logic              rf_rd,
   output logic              rf_wn,
   output logic              rf_stack_en,
   output logic              rf_push_en,
   output logic              rf_pop_en,
   output logic [ID_W-1:0]   rf_reg_id,
   output logic [DATA_W-1:0] rf_write_data,
   input  logic [DATA_W-1:0] rf_read_data
);

   typedef enum logic [2:0] {
      IDLE,
      READ_A,
      READ_B,
      CAP_B,
      CAP_A_ONLY,
      OUT
   } state_t;

   state_t state, state_nxt;

   logic [ID_W-1:0] src_a_q;
   logic [ID_W-1:0] src_b_q;
   logic            uses_b_q;
   logic [1:0]      stack_q;
   logic            accept;

   assign accept = dec_ready && dec_valid;

   always_comb begin
      state_nxt     = state;
      dec_ready     = 1'b0;
      wb_ready      = 1'b0;
      op_valid      = 1'b0;
      rf_rd         = 1'b0;
      rf_wn         = 1'b0;
      rf_stack_en   = 1'b0;
      rf_push_en    = 1'b0;
      rf_pop_en     = 1'b0;
      rf_reg_id     = '0;
      rf_write_data = '0;
      unique case (state)
         IDLE: begin
            // writeback wins so a same-cycle decode sees the new value
            if (wb_valid) begin
               rf_wn         = 1'b1;
               wb_ready      = 1'b1;
               rf_reg_id     = wb_reg;
               rf_write_data = wb_data;
            end else begin
               dec_ready = 1'b1;
               if (dec_valid) state_nxt = READ_A;
            end
         end
         READ_A: begin
            rf_rd     = 1'b1;
            rf_reg_id = src_a_q;
            state_nxt = uses_b_q ? READ_B : CAP_A_ONLY;
         end
         READ_B: begin
            rf_rd     = 1'b1;
            rf_reg_id = src_b_q;
            state_nxt = CAP_B;
         end
         CAP_B:      state_nxt = OUT;
         CAP_A_ONLY: state_nxt = OUT;
         OUT: begin
            op_valid = 1'b1;
            if (op_ready) begin
               state_nxt = IDLE;
               if (stack_q == 2'b01) begin
                  rf_stack_en = 1'b1;
                  rf_push_en  = 1'b1;
               end else if (stack_q == 2'b10) begin
                  rf_stack_en = 1'b1;
                  rf_pop_en   = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         src_a_q  <= '0;
         src_b_q  <= '0;
         uses_b_q <= 1'b0;
         stack_q  <= 2'b00;
         op_a     <= '0;
         op_b     <= '0;
         op_dst   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            src_a_q  <= dec_src_a;
            src_b_q  <= dec_src_b;
            uses_b_q <= dec_uses_b;
            stack_q  <= dec_stack_op;
            op_dst   <= dec_dst;
         end
         // read data trails the strobe by one cycle
         if (state == READ_B) op_a <= rf_read_data;
         if (state == CAP_B) op_b <= rf_read_data;
         if (state == CAP_A_ONLY) begin
            op_a <= rf_read_data;
            op_b <= '0;
         end
      end
   end

   a_rd_wn: assert property (@(posedge clk) disable iff (reset)
      !(rf_rd && rf_wn));
   a_stack_excl: assert property (@(posedge clk) disable iff (reset)
      !(rf_stack_en && (rf_rd || rf_wn)));
   a_push_pop: assert property (@(posedge clk) disable iff (reset)
      !(rf_push_en && rf_pop_en));
   a_pulse: assert property (@(posedge clk) disable iff (reset)
      rf_stack_en |=> !rf_stack_en);

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Randomized scoreboard bench for operand_fetch_unit with a
// behavioural register-file model and reference register array.
`timescale 1ns/100ps
module tb_operand_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        dec_valid, dec_ready;
   logic [3:0]  dec_src_a, dec_src_b, dec_dst;
   logic        dec_uses_b;
   logic [1:0]  dec_stack_op;
   logic        op_valid, op_ready;
   logic [15:0] op_a, op_b;
   logic [3:0]  op_dst;
   logic        wb_valid, wb_ready;
   logic [3:0]  wb_reg;
   logic [15:0] wb_data;
   logic        rf_rd, rf_wn, rf_stack_en, rf_push_en, rf_pop_en;
   logic [3:0]  rf_reg_id;
   logic [15:0] rf_write_data, rf_read_data;

   operand_fetch_unit #(.DATA_W(16), .ID_W(4)) dut (
      .clk(clk), .reset(reset),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_src_a(dec_src_a), .dec_src_b(dec_src_b),
      .dec_uses_b(dec_uses_b), .dec_dst(dec_dst),
      .dec_stack_op(dec_stack_op),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b), .op_dst(op_dst),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_reg(wb_reg), .wb_data(wb_data),
      .rf_rd(rf_rd), .rf_wn(rf_wn), .rf_stack_en(rf_stack_en),
      .rf_push_en(rf_push_en), .rf_pop_en(rf_pop_en),
      .rf_reg_id(rf_reg_id), .rf_write_data(rf_write_data),
      .rf_read_data(rf_read_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // register file driven only by the DUT strobes
   logic [15:0] mem [16];
   logic [15:0] rd_q;
   always @(posedge clk) begin
      if (rf_wn) mem[rf_reg_id] <= rf_write_data;
      if (rf_stack_en && rf_push_en) mem[2] <= mem[2] + 16'd1;
      else if (rf_stack_en && rf_pop_en) mem[2] <= mem[2] - 16'd1;
      if (rf_rd) rd_q <= mem[rf_reg_id];
   end
   assign rf_read_data = rd_q;

   logic [15:0] ref_r [16];

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  dst;
      logic [1:0]  sop;
      int          lat;
      int          acc_cyc;
   } exp_t;
   exp_t q[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [2:0] stack_code(input logic [1:0] s);
      if (s == 2'b01) return 3'b110;
      if (s == 2'b10) return 3'b101;
      return 3'b000;
   endfunction

   // monitor: compares DUT outputs against queued expectations
   bit seen_valid = 0;
   int rd_cnt = 0;
   initial forever begin
      @(negedge clk);
      #2;
      if (reset) begin
         q.delete();
         seen_valid = 0;
         rd_cnt = 0;
      end else begin
         logic [2:0] es;
         bit busy;
         busy = (q.size() > 0) && (cyc > q[0].acc_cyc);
         chk("rd_wn_excl", {63'd0, rf_rd && rf_wn}, 64'd0);
         if (busy) begin
            chk("wb_ready_busy", {63'd0, wb_ready}, 64'd0);
            chk("dec_ready_busy", {63'd0, dec_ready}, 64'd0);
         end
         if (rf_rd) rd_cnt++;
         es = 3'b000;
         if (op_valid && op_ready && q.size() > 0)
            es = stack_code(q[0].sop);
         if (rf_stack_en || rf_push_en || rf_pop_en || es != 3'b000)
            chk("stack_pulse",
                {61'd0, rf_stack_en, rf_push_en, rf_pop_en},
                {61'd0, es});
         if (op_valid) begin
            if (q.size() == 0) begin
               chk("op_valid_unexpected", 64'd1, 64'd0);
            end else begin
               if (!seen_valid) begin
                  chk("latency", 64'(cyc - q[0].acc_cyc),
                      64'(q[0].lat));
                  chk("rd_count", 64'(rd_cnt),
                      64'(q[0].lat == 4 ? 2 : 1));
                  seen_valid = 1;
               end
               chk("op_a", {48'd0, op_a}, {48'd0, q[0].a});
               chk("op_b", {48'd0, op_b}, {48'd0, q[0].b});
               chk("op_dst", {60'd0, op_dst}, {60'd0, q[0].dst});
               if (op_ready) begin
                  void'(q.pop_front());
                  seen_valid = 0;
                  rd_cnt = 0;
               end
            end
         end
      end
   end

   task automatic do_wb(input logic [3:0] r, input logic [15:0] d);
      int t;
      @(negedge clk);
      wb_valid = 1'b1;
      wb_reg = r;
      wb_data = d;
      #1;
      t = 0;
      while (!wb_ready && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (!wb_ready) chk("wb_timeout", 64'd0, 64'd1);
      else ref_r[r] = d;
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
   endtask

   task automatic issue(input logic [3:0] a, input logic [3:0] b,
                        input logic ub, input logic [3:0] dst,
                        input logic [1:0] sop, input int hold,
                        input bit wait_done);
      int t;
      exp_t e;
      @(negedge clk);
      dec_valid = 1'b1;
      dec_src_a = a;
      dec_src_b = b;
      dec_uses_b = ub;
      dec_dst = dst;
      dec_stack_op = sop;
      op_ready = (hold == 0);
      #1;
      t = 0;
      while (!dec_ready && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (!dec_ready) begin
         chk("dec_timeout", 64'd0, 64'd1);
         dec_valid = 1'b0;
         return;
      end
      e.a = ref_r[a];
      e.b = ub ? ref_r[b] : 16'h0000;
      e.dst = dst;
      e.sop = sop;
      e.lat = ub ? 4 : 3;
      e.acc_cyc = cyc;
      q.push_back(e);
      if (sop == 2'b01) ref_r[2] = ref_r[2] + 16'd1;
      else if (sop == 2'b10) ref_r[2] = ref_r[2] - 16'd1;
      @(posedge clk);
      #1;
      dec_valid = 1'b0;
      if (!wait_done) return;
      t = 0;
      do begin
         @(negedge clk);
         #1;
         t++;
      end while (!op_valid && t < 50);
      if (!op_valid) begin
         chk("op_valid_timeout", 64'd0, 64'd1);
         op_ready = 1'b1;
         return;
      end
      repeat (hold) begin
         @(negedge clk);
         #1;
      end
      op_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      dec_valid = 0; dec_src_a = 0; dec_src_b = 0;
      dec_uses_b = 0; dec_dst = 0; dec_stack_op = 0;
      op_ready = 1'b1;
      wb_valid = 0; wb_reg = 0; wb_data = 0;
      for (int i = 0; i < 16; i++) ref_r[i] = 16'h0000;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_op_valid", {63'd0, op_valid}, 64'd0);
      chk("rst_op_a", {48'd0, op_a}, 64'd0);
      chk("rst_op_b", {48'd0, op_b}, 64'd0);
      chk("rst_op_dst", {60'd0, op_dst}, 64'd0);
      chk("rst_strobes", {59'd0, rf_rd, rf_wn, rf_stack_en,
          rf_push_en, rf_pop_en}, 64'd0);
      chk("rst_reg_id", {60'd0, rf_reg_id}, 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 16; i++)
         do_wb(4'(i), 16'($urandom));

      // two-operand fetch
      do_wb(4'd3, 16'h1234);
      do_wb(4'd5, 16'hBEEF);
      issue(4'd3, 4'd5, 1'b1, 4'd7, 2'b00, 0, 1);
      // single operand
      issue(4'd5, 4'd9, 1'b0, 4'd1, 2'b00, 0, 1);

      // push under backpressure, then read the stack pointer
      do_wb(4'd2, 16'h0010);
      issue(4'd2, 4'd3, 1'b1, 4'd2, 2'b01, 6, 1);
      issue(4'd2, 4'd2, 1'b1, 4'd0, 2'b00, 0, 1);
      chk("r2_after_push", {48'd0, ref_r[2]}, 64'h0011);

      // writeback and decode arrive together
      @(negedge clk);
      wb_valid = 1'b1; wb_reg = 4'd4; wb_data = 16'h00AA;
      dec_valid = 1'b1; dec_src_a = 4'd4; dec_src_b = 4'd4;
      dec_uses_b = 1'b0; dec_dst = 4'd4; dec_stack_op = 2'b00;
      #1;
      chk("dec_ready_wb_prio", {63'd0, dec_ready}, 64'd0);
      chk("wb_ready_prio", {63'd0, wb_ready}, 64'd1);
      ref_r[4] = 16'h00AA;
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      issue(4'd4, 4'd4, 1'b0, 4'd4, 2'b00, 0, 1);

      // pop wraps R2; writeback raised mid-fetch must wait
      do_wb(4'd2, 16'h0000);
      fork
         issue(4'd2, 4'd2, 1'b1, 4'd8, 2'b10, 0, 1);
         begin
            repeat (2) @(negedge clk);
            do_wb(4'd6, 16'h5A5A);
         end
      join
      issue(4'd2, 4'd6, 1'b1, 4'd3, 2'b00, 0, 1);
      chk("r2_after_pop", {48'd0, ref_r[2]}, 64'hFFFF);

      // reset while in CAP_B abandons the instruction
      issue(4'd1, 4'd3, 1'b1, 4'd9, 2'b00, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_op_valid", {63'd0, op_valid}, 64'd0);
      chk("mid_rst_op_a", {48'd0, op_a}, 64'd0);
      chk("mid_rst_strobes", {59'd0, rf_rd, rf_wn, rf_stack_en,
          rf_push_en, rf_pop_en}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      issue(4'd3, 4'd1, 1'b1, 4'd5, 2'b01, 1, 1);

      // randomized mix
      for (int n = 0; n < 60; n++) begin
         int k;
         k = $urandom_range(0, 9);
         if (k < 3) begin
            do_wb(4'($urandom), 16'($urandom));
         end else if (k < 5) begin
            fork
               issue(4'($urandom), 4'($urandom), 1'($urandom),
                     4'($urandom), 2'($urandom),
                     $urandom_range(0, 3), 1);
               begin
                  repeat ($urandom_range(0, 5)) @(negedge clk);
                  do_wb(4'($urandom), 16'($urandom));
               end
            join
         end else begin
            issue(4'($urandom), 4'($urandom), 1'($urandom),
                  4'($urandom), 2'($urandom),
                  $urandom_range(0, 3), 1);
         end
      end

      repeat (4) @(negedge clk);
      #3;
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/operand_fetch_unit.md
Name: operand_fetch_unit

Overview:
- Sequencer directly upstream of the single-port 16x16 register file.
- Accepts decoded instructions and issues the register-file reads for up to two source operands.
- Presents the operand pair to the ALU stage with a valid/ready handshake.
- Also owns register-file writeback and stack-pointer push/pop pulses, so the rd/wn/stack controls are never driven by more than one master.

Parameters:
- DATA_W, 16, register and operand width
- ID_W, 4, register index width (2**ID_W registers)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dec_valid  in  1  decoded instruction available
- dec_ready  out  1  unit accepts the instruction this cycle
- dec_src_a  in  ID_W  first source register
- dec_src_b  in  ID_W  second source register
- dec_uses_b  in  1  instruction needs the second operand
- dec_dst  in  ID_W  destination register, passed through
- dec_stack_op  in  2  00 none, 01 push, 10 pop, 11 reserved (treated as none)
- op_valid  out  1  operands valid to ALU
- op_ready  in  1  ALU accepts operands
- op_a  out  DATA_W  first operand
- op_b  out  DATA_W  second operand (0 when !uses_b)
- op_dst  out  ID_W  latched destination
- wb_valid  in  1  writeback request
- wb_ready  out  1  writeback performed this cycle
- wb_reg  in  ID_W  writeback register index
- wb_data  in  DATA_W  writeback data
- rf_rd  out  1  register-file read strobe
- rf_wn  out  1  register-file write strobe
- rf_stack_en  out  1  stack-pointer update enable
- rf_push_en  out  1  increment stack pointer (register 2)
- rf_pop_en  out  1  decrement stack pointer
- rf_reg_id  out  ID_W  register index
- rf_write_data  out  DATA_W  write data
- rf_read_data  in  DATA_W  register-file read data, valid the cycle after rf_rd

Behaviour:
- Reset:
  - State is IDLE.
  - op_valid, op_a, op_b, op_dst, and all rf_* strobes are 0.
  - rf_reg_id is 0.
  - Reset mid-operation abandons the instruction; no read, write or stack pulse is issued afterwards.
- States: IDLE, READ_A, READ_B, CAP_B, CAP_A_ONLY, OUT.
- IDLE:
  - If wb_valid: drive rf_wn=1, rf_reg_id=wb_reg, rf_write_data=wb_data, and wb_ready=1 (combinational) for exactly one cycle. dec_ready=0. Stay in IDLE.
  - Otherwise dec_ready=1. On dec_valid, latch src_a, src_b, uses_b, dst and stack_op, then go to READ_A.
  - Writeback has strict priority over decode.
- READ_A: rf_rd=1, rf_reg_id=src_a. Next state is READ_B if uses_b, else CAP_A_ONLY.
- READ_B: rf_rd=1, rf_reg_id=src_b; capture op_a <= rf_read_data. Next state is CAP_B.
- CAP_B: capture op_b <= rf_read_data. Next state is OUT.
- CAP_A_ONLY: capture op_a <= rf_read_data; op_b <= 0. Next state is OUT.
- OUT:
  - op_valid=1; op_a, op_b and op_dst are held stable until op_ready.
  - On op_valid && op_ready:
    - If stack_op==01, assert rf_stack_en=1 and rf_push_en=1 in that same cycle only.
    - If stack_op==10, assert rf_stack_en=1 and rf_pop_en=1 in that same cycle only.
    - Return to IDLE.
- Latency: dec handshake to op_valid is 4 cycles with two operands, 3 cycles with one.
- Throughput: at most one instruction every 4 or 5 cycles; no overlap between instructions.
- Mutual exclusion invariants (checked by assertion):
  - rf_rd and rf_wn are never high together.
  - Stack pulses never coincide with rf_rd or rf_wn.
  - push_en and pop_en are never high together.
  - Every stack pulse is exactly one cycle wide.
- wb_ready=0 and dec_ready=0 in every non-IDLE state. A writeback arriving mid-fetch waits, so reads always observe writes completed before the instruction was accepted.
- src_a == src_b is legal; the same register is read twice.
- A source equal to a pending (not yet accepted) writeback reads the old value. The ordering hazard is the pipeline controller's responsibility.

Test Plan:
- Reset, then preload R3=0x1234 and R5=0xBEEF via wb. Issue src_a=3, src_b=5, uses_b=1, dst=7 -> op_valid 4 cycles after accept; op_a=0x1234, op_b=0xBEEF, op_dst=7.
- uses_b=0, src_a=5 -> op_valid after 3 cycles; op_a=0xBEEF, op_b=0x0000; rf_rd high for exactly 1 cycle.
- Hold op_ready=0 for 6 cycles in OUT, stack_op=push, R2=0x0010 -> operands stable, single-cycle push pulse on the op_ready cycle; R2 reads back 0x0011.
- wb_valid and dec_valid asserted together in IDLE (wb R4=0x00AA, dec src_a=4) -> write first, dec_ready=0 that cycle; fetched op_a=0x00AA.
- Pop with R2=0x0000 -> R2 wraps to 0xFFFF; wb_valid raised during READ_B is held with wb_ready=0 until IDLE.
- Assert reset in CAP_B -> next cycle state is IDLE, op_valid=0, no rf strobes; a subsequent instruction completes normally.
